// File: rtl/efuse_read_mode.sv
// eFuse read-back controller: serially reads the fuse word and
// compares it against the expected program word.
module efuse_read_mode #(
    parameter int NBITS   = 32,
    parameter int T_SETUP = 2,
    parameter int SCLK_HI = 2,
    parameter int SCLK_LO = 2,
    parameter int T_HOLD  = 2
) (
    input  logic             clk_1M,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vddq_on,
    input  logic [NBITS-1:0] exp_data,
    output logic             CSB,
    output logic             PGM,
    output logic             SCLK,
    output logic             DIN,
    input  logic             DOUT,
    output logic             busy,
    output logic [NBITS-1:0] rd_data,
    output logic             done,
    output logic             mismatch,
    output logic             err
);

    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int M1 = (T_SETUP > SCLK_HI) ? T_SETUP : SCLK_HI;
    localparam int M2 = (SCLK_LO > T_HOLD) ? SCLK_LO : T_HOLD;
    localparam int M3 = (M1 > M2) ? M1 : M2;
    localparam int CMAX = (M3 > IW) ? M3 : IW;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, HIGH, LOW, HOLD, FIN
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic             csb_q, csb_nxt;
    logic             sclk_q, sclk_nxt;
    logic             accept, refuse, capture, load;
    logic             refused;
    logic [NBITS-1:0] shift, exp_q;

    assign CSB  = csb_q;
    assign SCLK = sclk_q;
    assign PGM  = 1'b0;
    assign DIN  = 1'b0;

    // State, timing counters and registered macro pins
    always_ff @(posedge clk_1M or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            csb_q  <= 1'b1;
            sclk_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            csb_q  <= csb_nxt;
            sclk_q <= sclk_nxt;
        end
    end

    // Next-state sequencing of the read waveform
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        csb_nxt   = csb_q;
        sclk_nxt  = sclk_q;
        accept    = 1'b0;
        refuse    = 1'b0;
        capture   = 1'b0;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                csb_nxt  = 1'b1;
                sclk_nxt = 1'b0;
                if (start && vddq_on) begin
                    refuse    = 1'b1;
                    state_nxt = FIN;
                end else if (start) begin
                    accept    = 1'b1;
                    csb_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt == CW'(T_SETUP - 1)) begin
                    cnt_nxt   = '0;
                    sclk_nxt  = 1'b1;
                    state_nxt = HIGH;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (cnt == CW'(SCLK_HI - 1)) begin
                    cnt_nxt   = '0;
                    capture   = 1'b1;
                    sclk_nxt  = 1'b0;
                    state_nxt = LOW;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOW: begin
                if (cnt == CW'(SCLK_LO - 1)) begin
                    cnt_nxt = '0;
                    if (idx == IW'(NBITS - 1)) begin
                        state_nxt = HOLD;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        sclk_nxt  = 1'b1;
                        state_nxt = HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CW'(T_HOLD - 1)) begin
                    cnt_nxt   = '0;
                    csb_nxt   = 1'b1;
                    load      = 1'b1;
                    state_nxt = FIN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Data path: shift capture, result word and status flags
    always_ff @(posedge clk_1M or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            exp_q    <= '0;
            rd_data  <= '0;
            refused  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            done <= (state == FIN);
            err  <= (state == FIN) && refused;
            if (accept) begin
                exp_q   <= exp_data;
                busy    <= 1'b1;
                refused <= 1'b0;
            end
            if (refuse) begin
                refused <= 1'b1;
            end
            if (capture) begin
                shift[idx] <= DOUT;
            end
            if (load) begin
                rd_data <= shift;
            end
            if (state == FIN) begin
                busy <= 1'b0;
                if (!refused) begin
                    mismatch <= (shift != exp_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_efuse_read_mode.sv
// Directed bench for efuse_read_mode with a behavioural fuse
// macro; counts pin activity per read and checks results.
module tb_efuse_read_mode;

    logic        clk_1M = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        vddq_on = 1'b0;
    logic [31:0] exp_data = '0;
    logic        CSB, PGM, SCLK, DIN;
    logic        DOUT;
    logic        busy, done, mismatch, err;
    logic [31:0] rd_data;

    logic [31:0] fuse = '0;
    int          k;
    int          n_chk = 0;
    int          n_fail = 0;

    int          done_cyc, n_sclk, n_csb, n_hi, n_done, pin_bad;
    logic        err_at_done, busy_mid;

    efuse_read_mode dut (
        .clk_1M   (clk_1M),
        .rst_n    (rst_n),
        .start    (start),
        .vddq_on  (vddq_on),
        .exp_data (exp_data),
        .CSB      (CSB),
        .PGM      (PGM),
        .SCLK     (SCLK),
        .DIN      (DIN),
        .DOUT     (DOUT),
        .busy     (busy),
        .rd_data  (rd_data),
        .done     (done),
        .mismatch (mismatch),
        .err      (err)
    );

    always #500 clk_1M = ~clk_1M;

    // Fuse macro: next bit appears on each SCLK rise, CSB high rewinds
    always @(posedge SCLK or posedge CSB) begin
        if (CSB) begin
            k    <= 0;
            DOUT <= 1'b0;
        end else begin
            DOUT <= fuse[k];
            k    <= k + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // One read; cycle n is sampled 1 time unit after start edge + n
    task automatic run_read(input logic [31:0] f, input logic [31:0] e,
                            input logic v, input logic extra,
                            input int vmid_at, input int rst_at);
        logic prev;
        fuse     = f;
        exp_data = e;
        vddq_on  = v;
        done_cyc = -1;
        n_sclk   = 0;
        n_csb    = 0;
        n_hi     = 0;
        n_done   = 0;
        pin_bad  = 0;
        busy_mid = 1'b0;
        err_at_done = 1'b0;
        prev     = SCLK;
        @(negedge clk_1M);
        start = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk_1M);
            #1;
            start = 1'b0;
            if (n == 5) busy_mid = busy;
            if (SCLK && !prev) n_sclk++;
            prev = SCLK;
            if (SCLK) n_hi++;
            if (!CSB) n_csb++;
            if (PGM || DIN) pin_bad++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = n;
                    err_at_done = err;
                end
            end
            if (extra && (n == 10 || n == 70)) start = 1'b1;
            if (n == vmid_at) vddq_on = 1'b1;
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_csb", 32'(CSB), 32'd1);
                chk("rst_sclk", 32'(SCLK), 32'd0);
                chk("rst_rd", rd_data, 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                @(negedge clk_1M);
                rst_n = 1'b1;
                return;
            end
            if (done_cyc >= 0 && n >= done_cyc + 4) break;
        end
        vddq_on = 1'b0;
        if (done_cyc < 0) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1700;
        chk("r_csb", 32'(CSB), 32'd1);
        chk("r_pgm", 32'(PGM), 32'd0);
        chk("r_sclk", 32'(SCLK), 32'd0);
        chk("r_din", 32'(DIN), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_rd", rd_data, 32'd0);
        chk("r_flags", {29'd0, done, mismatch, err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_1M);

        run_read(32'h5555AAAA, 32'h5555AAAA, 1'b0, 1'b0, -1, -1);
        chk("a_done_cyc", 32'(done_cyc), 32'd133);
        chk("a_sclk", 32'(n_sclk), 32'd32);
        chk("a_hi", 32'(n_hi), 32'd64);
        chk("a_csb", 32'(n_csb), 32'd132);
        chk("a_ndone", 32'(n_done), 32'd1);
        chk("a_busy", 32'(busy_mid), 32'd1);
        chk("a_rd", rd_data, 32'h5555AAAA);
        chk("a_mis", 32'(mismatch), 32'd0);
        chk("a_err", 32'(err_at_done), 32'd0);
        chk("a_pins", 32'(pin_bad), 32'd0);
        chk("a_idle", 32'(busy), 32'd0);

        run_read(32'h5555AAAA, 32'h5555AAAB, 1'b0, 1'b0, -1, -1);
        chk("b_rd", rd_data, 32'h5555AAAA);
        chk("b_mis", 32'(mismatch), 32'd1);
        repeat (10) @(posedge clk_1M);
        #1;
        chk("b_mis_hold", 32'(mismatch), 32'd1);

        run_read(32'h0F0F0F0F, 32'h0F0F0F0F, 1'b1, 1'b0, -1, -1);
        chk("v_done_cyc", 32'(done_cyc), 32'd1);
        chk("v_err", 32'(err_at_done), 32'd1);
        chk("v_sclk", 32'(n_sclk), 32'd0);
        chk("v_csb", 32'(n_csb), 32'd0);
        chk("v_rd", rd_data, 32'h5555AAAA);
        chk("v_mis_keep", 32'(mismatch), 32'd1);

        run_read(32'h5555AAAA, 32'h5555AAAA, 1'b0, 1'b1, 20, -1);
        chk("x_done_cyc", 32'(done_cyc), 32'd133);
        chk("x_sclk", 32'(n_sclk), 32'd32);
        chk("x_ndone", 32'(n_done), 32'd1);
        chk("x_err", 32'(err_at_done), 32'd0);
        chk("x_rd", rd_data, 32'h5555AAAA);
        chk("x_mis", 32'(mismatch), 32'd0);

        run_read(32'h5555AAAA, 32'h5555AAAA, 1'b0, 1'b0, -1, 50);
        chk("rs_nodone", 32'(n_done), 32'd0);
        repeat (2) @(posedge clk_1M);
        run_read(32'h5555AAAA, 32'h5555AAAA, 1'b0, 1'b0, -1, -1);
        chk("rs_done_cyc", 32'(done_cyc), 32'd133);
        chk("rs_rd", rd_data, 32'h5555AAAA);
        chk("rs_mis", 32'(mismatch), 32'd0);

        run_read(32'h00000000, 32'h00000000, 1'b0, 1'b0, -1, -1);
        chk("z_rd", rd_data, 32'h00000000);
        chk("z_mis", 32'(mismatch), 32'd0);
        chk("z_pins", 32'(pin_bad), 32'd0);
        chk("z_sclk", 32'(n_sclk), 32'd32);

        run_read(32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, -1, -1);
        chk("f_rd", rd_data, 32'hFFFFFFFF);
        chk("f_mis", 32'(mismatch), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
